// File: rtl/mem_pkg.sv
// Shared memory-side types: store size encodings, byte-mask constants and the
// store buffer entry layout.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Address is held at its widest form; narrower buses zero-extend into it.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } store_entry_t;

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        logic [7:0] m;
        m = MASK_B;
        case (size)
            SZ_B: m = MASK_B;
            SZ_H: m = MASK_H;
            SZ_W: m = MASK_W;
            SZ_D: m = MASK_D;
            default: m = MASK_B;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align.sv
// Places a right-justified store into its 8-byte memory word and flags
// accesses that are not naturally aligned to their size.
module store_align
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       data,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] waddr,
    output logic [63:0]       wdata,
    output logic [7:0]        wmask,
    output logic              misaligned
);

    logic [2:0] off;
    logic [2:0] align_bits;

    // Offset bits that must be zero for a naturally aligned access of this size.
    always_comb begin
        off        = addr[2:0];
        align_bits = 3'b000;
        case (size)
            SZ_B: align_bits = 3'b000;
            SZ_H: align_bits = 3'b001;
            SZ_W: align_bits = 3'b011;
            SZ_D: align_bits = 3'b111;
            default: align_bits = 3'b000;
        endcase
        waddr      = {addr[ADDR_W-1:3], 3'b000};
        wdata      = data << {off, 3'b000};
        wmask      = base_mask(size) << off;
        misaligned = |(off & align_bits);
    end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between the LSU and the 64-bit data memory write port, with a
// same-word hit check for the load path.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [1:0]                 st_size,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [7:0]                 mem_wmask,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       misalign_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_err_q, misalign_err_d;
    store_entry_t     entries_q [DEPTH];
    store_entry_t     entries_d [DEPTH];

    logic [ADDR_W-1:0] al_waddr;
    logic [63:0]       al_wdata;
    logic [7:0]        al_wmask;
    logic              al_misaligned;

    logic accept;
    logic enq;
    logic deq;
    logic ld_addr_unused;
    store_entry_t head;

    store_align #(
        .ADDR_W(ADDR_W)
    ) u_align (
        .addr       (st_addr),
        .data       (st_data),
        .size       (st_size),
        .waddr      (al_waddr),
        .wdata      (al_wdata),
        .wmask      (al_wmask),
        .misaligned (al_misaligned)
    );

    assign st_ready     = (count_q != CNT_W'(DEPTH));
    assign mem_wvalid   = (count_q != '0);
    assign accept       = st_valid & st_ready;
    assign enq          = accept & ~al_misaligned;
    assign deq          = mem_wvalid & mem_wready;
    assign head         = entries_q[rptr_q];
    assign mem_waddr    = head.addr[ADDR_W-1:0];
    assign mem_wdata    = head.data;
    assign mem_wmask    = head.mask;
    assign count        = count_q;
    assign misalign_err = misalign_err_q;
    assign ld_addr_unused = ^ld_addr[2:0];

    always_comb begin
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        count_d        = count_q;
        misalign_err_d = accept & al_misaligned;
        entries_d      = entries_q;
        if (enq) begin
            entries_d[wptr_q].addr = 64'(al_waddr);
            entries_d[wptr_q].data = al_wdata;
            entries_d[wptr_q].mask = al_wmask;
            wptr_d = wptr_q + 1'b1;
        end
        if (deq) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel    = '0;
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - rptr_q;
            if ((CNT_W'(rel) < count_q) &&
                (entries_q[i].addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule
